// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - MESI snoop responder: L1 lookup, bus answer, downgrade/invalidate, M write-back
module snoop_responder #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2,
  parameter int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            snoop_op_in,
  input  logic [31:0]           snoop_addr_in,
  output logic                  snoop_hit_out,
  output logic [31:0]           snoop_data_out,
  output logic                  snoop_busy,
  output logic                  arr_req,
  output logic [INDEX_BITS-1:0] arr_index,
  input  logic [TAG_BITS-1:0]   arr_rtag,
  input  logic [1:0]            arr_rstate,
  input  logic [31:0]           arr_rdata,
  output logic                  arr_we,
  output logic [1:0]            arr_wstate,
  output logic                  wb_valid,
  output logic [31:0]           wb_addr,
  output logic [31:0]           wb_data,
  output logic                  protocol_err
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOOKUP  = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_UPGR = 2'd1;
  localparam logic [1:0] OP_NONE = 2'd3;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_E = 2'd2;
  localparam logic [1:0] MESI_M = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic        hit_q, hit_d;
  logic [31:0] data_q, data_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        perr_q, perr_d;
  logic        line_hit;
  logic [1:0]  new_state;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    hit_d      = hit_q;
    data_d     = data_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    perr_d     = perr_q;
    line_hit   = (arr_rstate != MESI_I) && (arr_rtag == addr_q[31 -: TAG_BITS]);
    new_state  = arr_rstate;
    if (line_hit) begin
      new_state = (op_q == OP_RD) ? MESI_S : MESI_I;
    end

    case (state_q)
      ST_IDLE: begin
        if (snoop_op_in != OP_NONE) begin
          op_d    = snoop_op_in;
          addr_d  = snoop_addr_in;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: state_d = ST_RESPOND;
      ST_RESPOND: begin
        state_d = ST_HOLD;
        hit_d   = line_hit;
        data_d  = (line_hit && op_q != OP_UPGR) ? arr_rdata : 32'd0;
        if (line_hit && op_q != OP_UPGR && arr_rstate == MESI_M) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = {addr_q[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          wb_data_d  = arr_rdata;
        end
        // Another core upgrading a line we own exclusively means the protocol broke.
        if (line_hit && op_q == OP_UPGR && (arr_rstate == MESI_E || arr_rstate == MESI_M)) begin
          perr_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (snoop_op_in == OP_NONE || snoop_op_in != op_q || snoop_addr_in != addr_q) begin
          state_d = ST_IDLE;
          hit_d   = 1'b0;
          data_d  = 32'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NONE;
      addr_q     <= 32'd0;
      hit_q      <= 1'b0;
      data_q     <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= 32'd0;
      wb_data_q  <= 32'd0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      hit_q      <= hit_d;
      data_q     <= data_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      perr_q     <= perr_d;
    end
  end

  assign snoop_busy     = (state_q == ST_LOOKUP) || (state_q == ST_RESPOND);
  assign arr_req        = (state_q == ST_LOOKUP);
  assign arr_index      = snoop_busy ? addr_q[OFFSET_BITS +: INDEX_BITS] : '0;
  // Gating with reset drops the state update when reset lands in RESPOND.
  assign arr_we         = (state_q == ST_RESPOND) && reset && line_hit && (new_state != arr_rstate);
  assign arr_wstate     = arr_we ? new_state : MESI_I;
  assign snoop_hit_out  = hit_q;
  assign snoop_data_out = data_q;
  assign wb_valid       = wb_valid_q;
  assign wb_addr        = wb_addr_q;
  assign wb_data        = wb_data_q;
  assign protocol_err   = perr_q;
endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - table-driven scoreboard bench for snoop_responder with an L1 array model
module tb_snoop_responder;
  localparam logic [1:0] RD = 2'd0, UPGR = 2'd1, RDX = 2'd2, NONE = 2'd3;
  localparam logic [1:0] I = 2'd0, S = 2'd1, E = 2'd2, M = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  snoop_op_in;
  logic [31:0] snoop_addr_in;
  logic        snoop_hit_out;
  logic [31:0] snoop_data_out;
  logic        snoop_busy;
  logic        arr_req;
  logic [5:0]  arr_index;
  logic [23:0] arr_rtag;
  logic [1:0]  arr_rstate;
  logic [31:0] arr_rdata;
  logic        arr_we;
  logic [1:0]  arr_wstate;
  logic        wb_valid;
  logic [31:0] wb_addr;
  logic [31:0] wb_data;
  logic        protocol_err;

  always #5 clk = ~clk;

  snoop_responder dut (
    .clk(clk), .reset(reset), .snoop_op_in(snoop_op_in), .snoop_addr_in(snoop_addr_in),
    .snoop_hit_out(snoop_hit_out), .snoop_data_out(snoop_data_out), .snoop_busy(snoop_busy),
    .arr_req(arr_req), .arr_index(arr_index), .arr_rtag(arr_rtag), .arr_rstate(arr_rstate),
    .arr_rdata(arr_rdata), .arr_we(arr_we), .arr_wstate(arr_wstate), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .protocol_err(protocol_err)
  );

  logic [23:0] m_tag   [64];
  logic [1:0]  m_state [64];
  logic [31:0] m_data  [64];
  logic        ld_en = 1'b0;
  logic [5:0]  ld_idx;
  logic [23:0] ld_tag;
  logic [1:0]  ld_state;
  logic [31:0] ld_data;
  int          req_cnt = 0;
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (ld_en) begin
      m_tag[ld_idx]   <= ld_tag;
      m_state[ld_idx] <= ld_state;
      m_data[ld_idx]  <= ld_data;
    end
    if (arr_req) begin
      arr_rtag   <= m_tag[arr_index];
      arr_rstate <= m_state[arr_index];
      arr_rdata  <= m_data[arr_index];
      req_cnt    <= req_cnt + 1;
    end
    if (arr_we) begin
      m_state[arr_index] <= arr_wstate;
      we_cnt             <= we_cnt + 1;
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [23:0] pre_tag;
    logic [1:0]  pre_state;
    logic [31:0] pre_data;
    logic        chk_resp;
    logic        hit;
    logic [31:0] data;
    logic        we;
    logic [1:0]  ws;
    logic        wb;
    logic        perr;
  } vec_t;

  vec_t vecs[11];
  vec_t exp_q[$];
  int   n_err = 0;
  int   n_checks = 0;

  function automatic vec_t mk(logic [1:0] op, logic [31:0] addr, logic [23:0] pt, logic [1:0] ps,
                              logic [31:0] pd, logic cr, logic hit, logic [31:0] data, logic we,
                              logic [1:0] ws, logic wb, logic perr);
    vec_t v;
    v.op = op; v.addr = addr; v.pre_tag = pt; v.pre_state = ps; v.pre_data = pd; v.chk_resp = cr;
    v.hit = hit; v.data = data; v.we = we; v.ws = ws; v.wb = wb; v.perr = perr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [23:0] tg, input logic [1:0] st,
                         input logic [31:0] d);
    ld_idx = idx; ld_tag = tg; ld_state = st; ld_data = d; ld_en = 1'b1;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    vec_t e;
    logic [31:0] a;
    a = v.addr;
    preload(a[7:2], v.pre_tag, v.pre_state, v.pre_data);
    snoop_op_in = v.op; snoop_addr_in = v.addr;
    exp_q.push_back(v);
    @(negedge clk);
    chk($sformatf("v%0d busy_c0", n), snoop_busy, 0);
    @(negedge clk);
    chk($sformatf("v%0d req_c1", n), arr_req, 1);
    chk($sformatf("v%0d index_c1", n), arr_index, a[7:2]);
    chk($sformatf("v%0d busy_c1", n), snoop_busy, 1);
    @(negedge clk);
    chk($sformatf("v%0d we_c2", n), arr_we, v.we);
    if (v.we) chk($sformatf("v%0d wstate_c2", n), arr_wstate, v.ws);
    chk($sformatf("v%0d busy_c2", n), snoop_busy, 1);
    @(negedge clk);
    e = exp_q.pop_front();
    if (e.chk_resp) begin
      chk($sformatf("v%0d hit_c3", n), snoop_hit_out, e.hit);
      chk($sformatf("v%0d data_c3", n), snoop_data_out, e.data);
      chk($sformatf("v%0d wbv_c3", n), wb_valid, e.wb);
      if (e.wb) begin
        chk($sformatf("v%0d wbaddr_c3", n), wb_addr, {e.addr[31:2], 2'b00});
        chk($sformatf("v%0d wbdata_c3", n), wb_data, e.pre_data);
      end
    end
    chk($sformatf("v%0d perr_c3", n), protocol_err, e.perr);
    chk($sformatf("v%0d busy_c3", n), snoop_busy, 0);
    snoop_op_in = NONE;
    @(negedge clk);
    chk($sformatf("v%0d hit_clr", n), snoop_hit_out, 0);
    chk($sformatf("v%0d data_clr", n), snoop_data_out, 0);
    chk($sformatf("v%0d wbv_c4", n), wb_valid, 0);
  endtask

  localparam logic [31:0] A = 32'h00ABCD14;

  initial begin
    int r0, w0;
    vecs[0]  = mk(RD,   A, 24'h00ABCD, M, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, S, 1, 0);
    vecs[1]  = mk(RDX,  A, 24'h00ABCD, E, 32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 1, I, 0, 0);
    vecs[2]  = mk(RD,   A, 24'h00ABCD, S, 32'h01234567, 1, 1, 32'h01234567, 0, S, 0, 0);
    vecs[3]  = mk(RDX,  A, 24'h00ABCD, S, 32'h89ABCDEF, 1, 1, 32'h89ABCDEF, 1, I, 0, 0);
    vecs[4]  = mk(UPGR, A, 24'h00ABCD, S, 32'hDEADBEEF, 1, 1, 32'h0,        1, I, 0, 0);
    vecs[5]  = mk(RDX,  A, 24'h00ABCD, M, 32'hFEEDFACE, 1, 1, 32'hFEEDFACE, 1, I, 1, 0);
    vecs[6]  = mk(RD,   A, 24'h00ABCE, M, 32'hDEADBEEF, 1, 0, 32'h0,        0, I, 0, 0);
    vecs[7]  = mk(RD,   A, 24'h00ABCD, I, 32'hDEADBEEF, 1, 0, 32'h0,        0, I, 0, 0);
    vecs[8]  = mk(RD,   A, 24'h00ABCD, E, 32'h55AA55AA, 1, 1, 32'h55AA55AA, 1, S, 0, 0);
    vecs[9]  = mk(RD,   32'h7654ABFC, 24'h7654AB, S, 32'h0BADF00D, 1, 1, 32'h0BADF00D, 0, S, 0, 0);
    vecs[10] = mk(UPGR, A, 24'h00ABCD, M, 32'hDEADBEEF, 0, 1, 32'h0,        1, I, 0, 1);

    reset = 1'b0; snoop_op_in = NONE; snoop_addr_in = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst hit", snoop_hit_out, 0);
    chk("rst data", snoop_data_out, 0);
    chk("rst busy", snoop_busy, 0);
    chk("rst req", arr_req, 0);
    chk("rst index", arr_index, 0);
    chk("rst we", arr_we, 0);
    chk("rst wstate", arr_wstate, 0);
    chk("rst wbv", wb_valid, 0);
    chk("rst wbaddr", wb_addr, 0);
    chk("rst wbdata", wb_data, 0);
    chk("rst perr", protocol_err, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    for (int k = 0; k < 11; k++) run_vec(vecs[k], k);

    // Op held for 10 cycles, then released, then a fresh BusRdX elsewhere.
    preload(6'd7, 24'h123456, E, 32'hCAFEF00D);
    preload(6'd5, 24'h00ABCD, M, 32'hDEADBEEF);
    r0 = req_cnt; w0 = we_cnt;
    snoop_op_in = RD; snoop_addr_in = A;
    repeat (10) @(negedge clk);
    chk("hold req count", req_cnt - r0, 1);
    chk("hold we count", we_cnt - w0, 1);
    chk("hold hit", snoop_hit_out, 1);
    chk("hold data", snoop_data_out, 32'hDEADBEEF);
    chk("hold perr sticky", protocol_err, 1);
    snoop_op_in = NONE;
    @(negedge clk);
    chk("release hit", snoop_hit_out, 0);
    chk("release data", snoop_data_out, 0);
    snoop_op_in = RDX; snoop_addr_in = 32'h1234561C;
    repeat (3) @(negedge clk);
    chk("next hit", snoop_hit_out, 1);
    chk("next data", snoop_data_out, 32'hCAFEF00D);
    chk("next line state", m_state[7], I);
    snoop_op_in = NONE;
    @(negedge clk);

    // Reset asserted while in RESPOND.
    preload(6'd9, 24'h0F0F0F, M, 32'h11112222);
    snoop_op_in = RD; snoop_addr_in = 32'h0F0F0F24;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid we", arr_we, 0);
    @(posedge clk);
    #1 reset = 1'b1; snoop_op_in = NONE;
    @(negedge clk);
    chk("rstmid hit", snoop_hit_out, 0);
    chk("rstmid data", snoop_data_out, 0);
    chk("rstmid wbv", wb_valid, 0);
    chk("rstmid busy", snoop_busy, 0);
    chk("rstmid req", arr_req, 0);
    chk("rstmid perr", protocol_err, 0);
    chk("rstmid line state", m_state[9], M);
    repeat (2) @(negedge clk);
    chk("rstmid idle busy", snoop_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/snoop_responder.md
# snoop_responder

Per-core snoop responder: the answering end of the two-core MESI bus. It watches the bus operation/address forwarded to this core by `bus_controller`, looks the line up in the core's L1 tag/state/data array, and returns hit and data to `bus_controller`. It downgrades or invalidates the local line and emits a Modified-line write-back toward L2. There is one instance per core, between the L1 array's snoop port and `bus_controller`.

## Interface
- `INDEX_BITS`, default 6: L1 index width (64 lines).
- `OFFSET_BITS`, default 2: byte offset within the one-word line.
- `TAG_BITS`, default 32-INDEX_BITS-OFFSET_BITS: stored tag width.
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-low (asserted when 0).
- `snoop_op_in`  in  2  bus operation from `bus_controller`: BusRd=00, BusUpgr=01, BusRdX=10, none=11.
- `snoop_addr_in`  in  32  snooped byte address.
- `snoop_hit_out`  out  1  line present (state != I); feeds `bus_controller` `cache_hit_in`.
- `snoop_data_out`  out  32  line data; feeds `bus_controller` `bus_data_in`.
- `snoop_busy`  out  1  array claimed by snoop; the L1 pipeline must not access the array.
- `arr_req`  out  1  array read strobe.
- `arr_index`  out  INDEX_BITS  array index.
- `arr_rtag`  in  TAG_BITS  read tag, valid the cycle after `arr_req`.
- `arr_rstate`  in  2  read MESI state: I=00, S=01, E=10, M=11.
- `arr_rdata`  in  32  read data word.
- `arr_we`  out  1  state write strobe.
- `arr_wstate`  out  2  new MESI state written at `arr_index`.
- `wb_valid`  out  1  one-cycle pulse: a Modified line is written back to L2.
- `wb_addr`  out  32  write-back address (word aligned).
- `wb_data`  out  32  write-back data.
- `protocol_err`  out  1  sticky: BusUpgr snooped a line held in E or M.

## Operation
- Address split: index = addr[OFFSET_BITS +: INDEX_BITS]; tag = addr[31 -: TAG_BITS].
- States: IDLE, LOOKUP, RESPOND, HOLD.
- IDLE: if `snoop_op_in` != 11, latch op and address, go to LOOKUP.
- LOOKUP: `arr_req`=1 and `arr_index` = latched index; go to RESPOND.
- RESPOND: hit = (`arr_rstate` != I) && (`arr_rtag` == latched tag). Next-state and output rules by op on a hit:
  - BusRd: M→S with write-back; E→S; S→S (no write). Hit and data are supplied.
  - BusRdX: M→I with write-back; E→I; S→I. Hit and data are supplied.
  - BusUpgr: S→I with hit=1 and data=0. E or M → I and set `protocol_err`.
  - Miss: no array write, hit=0, data=0.
  - `arr_we` is asserted only when the state changes.
  - Go to HOLD.
- HOLD: hold the registered `snoop_hit_out`/`snoop_data_out`. Exit to IDLE when `snoop_op_in`==11 or the op/address differs from the latched value. On exit the outputs clear to 0 and the unit does not re-service the same transaction.
- `snoop_busy` = 1 in LOOKUP and RESPOND.

## Timing
- Reset values:
  - FSM = IDLE.
  - `snoop_hit_out`, `snoop_data_out`, `snoop_busy`, `arr_req`, `arr_index`, `arr_we`, `arr_wstate`, `wb_valid`, `wb_addr`, `wb_data`, `protocol_err` all = 0.
- Cycle 0: op is valid in IDLE. Cycle 1: LOOKUP. Cycle 2: RESPOND, with `arr_we` combinational in this cycle.
- Cycle 3: `snoop_hit_out`/`snoop_data_out` valid (registered at the cycle-2 edge). `wb_valid` is high for cycle 3 only. Response latency is 3 cycles from op presentation.
- `bus_controller` and the requesting core hold the op stable, stalled, until cycle 3 or later.
- Op drops to 11 during LOOKUP or RESPOND: the lookup and state update still complete, and HOLD exits on its first cycle.
- A new op arriving in the same cycle HOLD exits is captured in the following IDLE cycle, so its cycle 0 is one cycle later.
- Reset mid-operation: immediate IDLE at the next edge. No `arr_we` or `wb_valid` is issued; any pending update is dropped.
- `protocol_err` is cleared only by reset.

## Test plan
- Index 5 holds tag 0x00ABCD, state M, data 0xDEADBEEF. BusRd to address of (tag 0x00ABCD, index 5) → cycle 2: `arr_we`=1, `arr_wstate`=S. Cycle 3: hit=1, data=0xDEADBEEF, `wb_valid` pulse with the same address and data.
- Same line in state E, BusRdX → cycle 2: `arr_wstate`=I. Cycle 3: hit=1, data=0xDEADBEEF, `wb_valid`=0.
- Line in state S, BusUpgr → cycle 2: I written. Cycle 3: hit=1, data=0. Repeat with the line in M → `protocol_err`=1 and stays 1.
- Tag mismatch, or state I → no `arr_we`; hit=0 and data=0 in cycle 3. `snoop_busy` is high for exactly cycles 1–2.
- Op held at BusRd for 10 cycles → exactly one lookup and one `arr_we`. Op goes to 11 → outputs 0 next cycle. A BusRdX on a different address immediately after → serviced as a new transaction.
- `reset`=0 asserted in RESPOND → no `arr_we`; next cycle all outputs 0 and FSM IDLE.
